// File: rtl/fir_engine.sv
// 11-tap FIR accelerator: AXI-Lite config, AXI-Stream in/out,
// taps and sample history held in two external single-port BRAMs.
module fir_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  output logic                   awready,
  output logic                   wready,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arready,
  input  logic                   rready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do,
  input  logic                   axis_clk,
  input  logic                   axis_rst_n
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_IN, MAC, OUT
  } state_t;

  localparam logic [3:0] NT = 4'(Tape_Num);
  localparam logic [3:0] LAST_TAP = 4'(Tape_Num - 1);
  localparam logic [pADDR_WIDTH-1:0] CTRL_A = '0;
  localparam logic [pADDR_WIDTH-1:0] LEN_A = pADDR_WIDTH'('h10);
  localparam logic [pADDR_WIDTH-1:0] TAP_LO = pADDR_WIDTH'('h20);
  localparam logic [pADDR_WIDTH-1:0] TAP_HI = pADDR_WIDTH'('h48);

  state_t state, state_d;
  logic [3:0] cnt, wptr, dptr;
  logic [pDATA_WIDTH-1:0] data_length, remain;
  logic [pDATA_WIDTH-1:0] acc, prod, rd_val;
  logic start_bit, done, idle, aw_ack;
  logic [1:0] rph;
  logic [pADDR_WIDTH-1:0] raddr;
  logic wr_fire, start_req, wr_tap, rd_tap;
  logic unused_tlast;

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_LO) && (a <= TAP_HI) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [pADDR_WIDTH-1:0] waddr(input logic [3:0] i);
    return pADDR_WIDTH'({i, 2'b00});
  endfunction

  assign unused_tlast = ss_tlast;
  assign awready = aw_ack;
  assign wready  = aw_ack;
  assign arready = (rph == 2'd1);
  assign rvalid  = (rph == 2'd3);

  // Writes wait out the read-address cycle so the tap port never collides
  assign wr_fire = !axis_rst_n && awvalid && wvalid && !aw_ack
                   && (rph != 2'd1);
  assign start_req = wr_fire && (awaddr == CTRL_A) && wdata[0]
                     && (state == IDLE);
  assign wr_tap = wr_fire && is_tap(awaddr) && (state == IDLE);
  assign rd_tap = (rph == 2'd1) && is_tap(raddr) && (state == IDLE);

  assign dptr = (wptr >= cnt) ? wptr - cnt : wptr + NT - cnt;
  assign prod = tap_Do * data_Do;

  always_comb begin
    state_d   = state;
    ss_tready = 1'b0;
    tap_EN    = 1'b0;
    tap_WE    = 4'h0;
    tap_A     = '0;
    tap_Di    = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;
    if (wr_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - TAP_LO;
      tap_Di = wdata;
    end else if (rd_tap) begin
      tap_EN = 1'b1;
      tap_A  = raddr - TAP_LO;
    end
    unique case (state)
      IDLE: begin
        if (start_req)
          state_d = (data_length == '0) ? IDLE : CLEAR;
      end
      CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = waddr(cnt);
        if (cnt == LAST_TAP) state_d = WAIT_IN;
      end
      WAIT_IN: begin
        if (ss_tvalid) begin
          ss_tready = 1'b1;
          data_EN   = 1'b1;
          data_WE   = 4'hF;
          data_A    = waddr(wptr);
          data_Di   = ss_tdata;
          state_d   = MAC;
        end
      end
      MAC: begin
        if (cnt <= LAST_TAP) begin
          tap_EN  = 1'b1;
          tap_A   = waddr(cnt);
          data_EN = 1'b1;
          data_A  = waddr(dptr);
        end
        if (cnt == NT) state_d = OUT;
      end
      OUT: begin
        if (sm_tready)
          state_d = (remain == 32'd1) ? IDLE : WAIT_IN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (raddr == CTRL_A)
      rd_val = {{(pDATA_WIDTH-3){1'b0}}, idle, done, start_bit};
    else if (raddr == LEN_A)
      rd_val = data_length;
    else if (is_tap(raddr))
      rd_val = (state == IDLE) ? tap_Do : '1;
  end

  always_ff @(posedge axis_clk or posedge axis_rst_n) begin
    if (axis_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wptr        <= '0;
      data_length <= '0;
      remain      <= '0;
      acc         <= '0;
      start_bit   <= 1'b0;
      done        <= 1'b0;
      idle        <= 1'b1;
      aw_ack      <= 1'b0;
      rph         <= 2'd0;
      raddr       <= '0;
      rdata       <= '0;
      sm_tvalid   <= 1'b0;
      sm_tdata    <= '0;
      sm_tlast    <= 1'b0;
    end else begin
      state  <= state_d;
      aw_ack <= wr_fire;
      cnt    <= (state_d != state) ? 4'd0 : cnt + 4'd1;
      if (wr_fire && awaddr == LEN_A) data_length <= wdata;
      unique case (rph)
        2'd0: begin
          if (arvalid) begin
            rph   <= 2'd1;
            raddr <= araddr;
          end
        end
        2'd1: rph <= 2'd2;
        2'd2: begin
          rph   <= 2'd3;
          rdata <= rd_val;
        end
        default: if (rready) rph <= 2'd0;
      endcase
      unique case (state)
        IDLE: begin
          if (start_req) begin
            if (data_length == '0) begin
              done <= 1'b1;
              idle <= 1'b1;
            end else begin
              done      <= 1'b0;
              idle      <= 1'b0;
              start_bit <= 1'b1;
              remain    <= data_length;
              wptr      <= '0;
            end
          end
        end
        CLEAR: if (state_d == WAIT_IN) start_bit <= 1'b0;
        WAIT_IN: if (ss_tvalid) acc <= '0;
        MAC: begin
          // Products trail the addresses by one cycle of BRAM latency
          if (cnt != 4'd0) begin
            acc <= acc + prod;
            if (cnt == NT) begin
              sm_tvalid <= 1'b1;
              sm_tdata  <= acc + prod;
              sm_tlast  <= (remain == 32'd1);
            end
          end
        end
        OUT: begin
          if (sm_tready) begin
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
            remain    <= remain - 32'd1;
            wptr      <= (wptr == LAST_TAP) ? 4'd0 : wptr + 4'd1;
            if (remain == 32'd1) begin
              done <= 1'b1;
              idle <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_engine.sv
// Directed self-checking bench for fir_engine with behavioural
// single-port BRAM models on the tap and data ports.
module tb_fir_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        awready, wready, awvalid, wvalid;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        arready, rready, arvalid, rvalid;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata, sm_tdata;
  logic        sm_tready, sm_tvalid, sm_tlast;
  logic [3:0]  tap_WE, data_WE;
  logic        tap_EN, data_EN;
  logic [31:0] tap_Di, tap_Do, data_Di, data_Do;
  logic [11:0] tap_A, data_A;

  logic [31:0] tap_mem [0:15];
  logic [31:0] data_mem [0:15];

  int checks = 0;
  int errors = 0;

  int h [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int imp_y [12] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0, 0};
  int step_y [11] = '{0, -10, -19, 4, 60, 123, 179, 202, 193, 183, 183};

  always #5 clk = ~clk;

  fir_engine dut (
    .awready(awready), .wready(wready), .awvalid(awvalid),
    .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
    .arready(arready), .rready(rready), .arvalid(arvalid),
    .araddr(araddr), .rvalid(rvalid), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata),
    .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tready(sm_tready), .sm_tvalid(sm_tvalid),
    .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di),
    .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di),
    .data_A(data_A), .data_Do(data_Do),
    .axis_clk(clk), .axis_rst_n(rst)
  );

  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= tap_mem[tap_A[5:2]];
    end
    if (data_EN) begin
      if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
      data_Do <= data_mem[data_A[5:2]];
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic logic outs_any();
    return |{awready, wready, arready, rvalid, rdata, ss_tready,
             sm_tvalid, sm_tdata, sm_tlast, tap_WE, tap_EN, tap_Di,
             tap_A, data_WE, data_EN, data_Di, data_A};
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    bit ok = 0;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready && wready) begin ok = 1; break; end
    end
    awvalid = 0; wvalid = 0;
    if (!ok) timeout("axi_write");
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    bit ok = 0;
    d = '0;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arready) begin ok = 1; break; end
    end
    arvalid = 0;
    if (!ok) begin timeout("arready"); return; end
    rready = 1; ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin ok = 1; d = rdata; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rready = 0;
    if (!ok) timeout("rvalid");
  endtask

  task automatic rd_check(input string tag, input logic [11:0] a,
                          input logic [31:0] exp);
    logic [31:0] v;
    axi_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic push(input string tag, input logic [31:0] x,
                      input logic [31:0] y, input logic last);
    bit ok = 0;
    ss_tdata = x; ss_tvalid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ss_tready) begin
        @(posedge clk); #1;
        ok = 1; break;
      end
    end
    ss_tvalid = 0;
    if (!ok) begin timeout({tag, "_ss"}); return; end
    sm_tready = 1; ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sm_tvalid) begin
        ok = 1;
        check(tag, sm_tdata, y);
        check({tag, "_last"}, 32'(sm_tlast), 32'(last));
        @(posedge clk); #1;
        break;
      end
    end
    sm_tready = 0;
    if (!ok) timeout({tag, "_sm"});
  endtask

  task automatic tri_run(input int scale, input int ofs);
    int hist [11];
    int x, y;
    hist = '{default: 0};
    axi_write(12'h10, 32'd600);
    axi_write(12'h00, 32'd1);
    for (int n = 0; n < 600; n++) begin
      x = (n % 40) < 20 ? (n % 40) : 40 - (n % 40);
      x = (x - 10) * scale + ofs;
      for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      y = 0;
      for (int k = 0; k < 11; k++) y += h[k] * hist[k];
      push("tri", x, y, n == 599);
    end
    rd_check("tri_done", 12'h00, 32'h6);
  endtask

  initial begin
    rst = 1; awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
    arvalid = 0; araddr = '0; rready = 0;
    ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs_any()), 32'd0);
    rst = 0;
    @(posedge clk); #1;

    rd_check("ctrl_reset", 12'h00, 32'h4);
    rd_check("len_reset", 12'h10, 32'h0);

    axi_write(12'h10, 32'd600);
    for (int k = 0; k < 11; k++) axi_write(12'(32'h20 + 4 * k), h[k]);
    for (int k = 0; k < 11; k++)
      rd_check("tap_readback", 12'(32'h20 + 4 * k), h[k]);
    rd_check("ctrl_idle", 12'h00, 32'h4);
    rd_check("len_600", 12'h10, 32'd600);
    rd_check("unmapped", 12'h100, 32'h0);

    axi_write(12'h10, 32'd0);
    axi_write(12'h00, 32'd1);
    rd_check("len0_done", 12'h00, 32'h6);

    axi_write(12'h10, 32'd12);
    axi_write(12'h00, 32'd1);
    rd_check("ctrl_starting", 12'h00, 32'h1);
    for (int n = 0; n < 12; n++)
      push("impulse", (n == 0) ? 32'd1 : 32'd0, imp_y[n], n == 11);
    rd_check("done_rd1", 12'h00, 32'h6);
    rd_check("done_rd2", 12'h00, 32'h6);

    axi_write(12'h10, 32'd11);
    axi_write(12'h00, 32'd1);
    axi_write(12'h24, 32'h1234);
    rd_check("tap_busy", 12'h24, 32'hFFFF_FFFF);
    for (int n = 0; n < 11; n++)
      push("step", 32'd1, step_y[n], n == 10);
    rd_check("tap_kept", 12'h24, 32'hFFFF_FFF6);

    tri_run(100, 0);
    tri_run(100, 7);
    tri_run(1 << 24, 3);

    axi_write(12'h10, 32'd5);
    axi_write(12'h00, 32'd1);
    ss_tdata = 32'd9; ss_tvalid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ss_tready) break;
    end
    @(posedge clk); #1;
    ss_tvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("in_mac", 32'(tap_EN), 32'd1);
    #2 rst = 1;
    #1 check("midrun_reset_outputs", 32'(outs_any()), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rd_check("ctrl_after_reset", 12'h00, 32'h4);
    axi_write(12'h10, 32'd3);
    axi_write(12'h00, 32'd1);
    push("fresh0", 32'd1, 32'd0, 1'b0);
    push("fresh1", 32'd2, -32'sd10, 1'b0);
    push("fresh2", 32'd3, -32'sd29, 1'b1);
    rd_check("fresh_done", 12'h00, 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_engine.md
# fir_engine

11-tap FIR filter accelerator: taps and a run length are programmed over AXI-Lite, samples enter on an AXI-Stream slave, and filtered results leave on an AXI-Stream master. Tap coefficients and the 11-sample history live in two external single-port 11-word BRAMs that the block drives directly. It sits between the CPU's AXI-Lite configuration bus and a streaming datapath, and can be re-run any number of times without reset.

## Interface
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width (byte addresses)
- pDATA_WIDTH, 32, data width of all buses
- Tape_Num, 11, number of taps
- axis_clk  in  1  single clock; everything is on its rising edge
- axis_rst_n  in  1  reset, asynchronous, active-high (1 = reset)
- awvalid/awready, wvalid/wready  in/out  1  AXI-Lite write address and data handshakes
- awaddr  in  pADDR_WIDTH; wdata  in  pDATA_WIDTH
- arvalid/arready  in/out  1; araddr  in  pADDR_WIDTH  AXI-Lite read address
- rvalid  out  1; rready  in  1; rdata  out  pDATA_WIDTH  AXI-Lite read data
- ss_tvalid  in  1; ss_tdata  in  pDATA_WIDTH; ss_tlast  in  1 (ignored); ss_tready  out  1  sample input
- sm_tvalid  out  1; sm_tdata  out  pDATA_WIDTH; sm_tlast  out  1; sm_tready  in  1  result output
- tap_WE  out  4; tap_EN  out  1; tap_Di  out  32; tap_A  out  12; tap_Do  in  32  tap BRAM port
- data_WE  out  4; data_EN  out  1; data_Di  out  32; data_A  out  12; data_Do  in  32  sample BRAM port
- BRAM contract: the BRAM decodes word index A[5:2]. Writes take effect at the clock edge when EN=1 and WE=4'hF. Do is registered, valid one cycle after A is presented with EN=1.

## Operation
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start (W1 starts a run), bit1 ap_done (RO), bit2 ap_idle (RO); other bits read 0.
  - 0x10 data_length (32 bit).
  - 0x20 + 4k, k = 0..10: tap h[k], stored in tap BRAM word k.
  - Unmapped addresses: writes are ignored, reads return 0.
- Tap reads:
  - While idle, reads return the tap BRAM contents.
  - While a run is active, tap reads return 0xFFFFFFFF.
  - Tap writes while a run is active are ignored.
- Status after reset: ap_idle=1, ap_done=0, data_length=0.
- Writing ap_start=1 while idle:
  - clears ap_done and ap_idle;
  - zeroes the 11 sample-BRAM words, one word per cycle over 11 cycles;
  - then begins accepting samples.
  - ap_start reads 1 only until the run begins, then returns to 0.
  - Writing ap_start while a run is active has no effect.
- Per sample: y[n] = Σ_{k=0..10} h[k]·x[n−k], with x[m]=0 for m<0 and the history zeroed at each run start.
- Arithmetic: 32×32 signed products, accumulated in a 32-bit register; keep the low 32 bits and wrap on overflow.
- Sample buffer: circular over words 0..10. The write pointer advances after each sample (mod 11), and h[k] is paired with the sample written k samples earlier.
- Run length: exactly data_length samples are consumed and data_length results produced.
  - sm_tlast=1 accompanies the last result.
  - When that result is accepted, set ap_done=1 and ap_idle=1.
  - ap_done stays 1 until the next ap_start, so repeated reads all return done.
- FSM states: IDLE → CLEAR (11 cycles) → WAIT_IN → MAC (11 tap/data reads plus 1 drain cycle) → OUT.
  - OUT goes to WAIT_IN if samples remain; otherwise it goes to IDLE and sets done.
- data_length=0: ap_start makes the block go straight to done/idle with no stream activity.

## Timing
- Reset (asynchronous, active-high) drives every output to 0: all ready/valid signals, rdata, sm_tdata, sm_tlast, BRAM EN/WE/A/Di. A reset mid-run aborts the run and returns to IDLE.
- AXI-Lite write:
  - Executes when awvalid and wvalid are both 1.
  - awready and wready pulse high together for exactly one cycle, registered, one cycle after both valids are seen.
  - The register or BRAM write commits on that same edge.
- AXI-Lite read:
  - arready pulses one cycle when arvalid=1.
  - rvalid rises two cycles later (BRAM latency included) and holds, with stable rdata, until rready=1.
  - No new read is accepted until the rvalid·rready handshake completes.
- ss_tready pulses for one cycle only in WAIT_IN, and only while ss_tvalid=1. The sample is captured on that edge, so back-to-back samples are at least 13 cycles apart.
- sm_tvalid rises at most 14 cycles after the sample handshake. It holds, together with sm_tdata and sm_tlast, until sm_tready=1, then drops for at least one cycle.
- The next sample is not accepted until the previous result has been accepted.

## Test plan
- Config readback: taps {0,−10,−9,23,56,63,56,23,−9,−10,0} and data_length=600 → each of 0x20..0x48 reads back its tap; 0x00 reads 0x4 (idle).
- Impulse: data_length=12, x = 1,0,…,0 → outputs 0,−10,−9,23,56,63,56,23,−9,−10,0,0; sm_tlast only on the 12th.
- Step: 11 samples of 1 → running sums 0,−10,−19,4,60,123,179,202,193,183,183.
- Completion: after the last result, two consecutive reads of 0x00 both return bit1=1 and bit2=1. A tap write issued mid-run is ignored, and a tap read mid-run returns 0xFFFFFFFF.
- Three back-to-back 600-sample triangular-wave runs with no reset in between → every run matches the reference output, because the history is zeroed on each ap_start.
- Async reset during MAC → all outputs 0 immediately; 0x00 reads 0x4; a fresh run then produces correct results.
